// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and default parameters.
// Latency: none (package only).
// Backpressure: n/a.
package uart_arb_pkg;

   // Default configuration of the arbiter.
   localparam int ARB_NUM_REQ_DEF   = 4;
   localparam int ARB_DATA_BITS_DEF = 8;
   localparam int ARB_TIMEOUT_DEF   = 64;

   // Transaction FSM: IDLE -> START -> BUSY -> DONE -> IDLE.
   // START -> DONE directly is the abort path when the timeout feature is built in.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner search: first requester found at last_winner+1, +2, ... modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
// Ports: req (request vector), last_winner (index of the previous owner),
//        winner (selected index, only meaningful when valid), valid (any request present).
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = ARB_NUM_REQ_DEF,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_winner,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      winner = last_winner;
      valid  = 1'b0;
      cand   = '0;
      // offset NUM_REQ wraps back to last_winner itself, so a lone requester
      // is re-granted after its own turn
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((int'(last_winner) + off) % NUM_REQ);
         if (!valid && req[cand]) begin
            valid  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte requesters onto one UART transmitter with round-robin fairness.
// Latency: request seen in IDLE gives Transmit_Start/Grant/Tx_Data one cycle later; Ack one cycle after Tx_Busy falls.
// Backpressure: Tx_Busy or BIST_Busy hold new grants in IDLE; Req is held by the requester until its Ack.
// Ports: Clk/Rst_n (baud clock, async active-low reset); Req/Req_Data (per-requester request and byte);
//        Grant/Ack (one-hot owner and completion pulse); Tx_Data/Transmit_Start/Tx_Busy (UART transmitter side);
//        BIST_Busy (self-test blocks new grants); Arb_Busy (FSM not IDLE); Timeout (abort pulse).
// Build option: define UART_ARB_TIMEOUT_EN to abort a START that sees no Tx_Busy within TIMEOUT_CYCLES.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ        = ARB_NUM_REQ_DEF,
   parameter int DATA_BITS      = ARB_DATA_BITS_DEF,
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEF
) (
   input  logic                         Clk,
   input  logic                         Rst_n,
   input  logic [NUM_REQ-1:0]           Req,
   input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
   output logic [NUM_REQ-1:0]           Grant,
   output logic [NUM_REQ-1:0]           Ack,
   output logic [DATA_BITS-1:0]         Tx_Data,
   output logic                         Transmit_Start,
   input  logic                         Tx_Busy,
   input  logic                         BIST_Busy,
   output logic                         Arb_Busy,
   output logic                         Timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_BITS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("uart_tx_arbiter: parameter out of range");
   end

   arb_state_t             state;
   arb_state_t             state_nxt;
   logic [NUM_REQ-1:0]     grant;
   logic [DATA_BITS-1:0]   tx_data;
   logic [IDX_W-1:0]       win_idx;
   logic [IDX_W-1:0]       last_winner;

   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_vld;
   logic [NUM_REQ-1:0]     pick_onehot;
   logic [DATA_BITS-1:0]   pick_data;
   logic                   to_hit;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req         (Req),
      .last_winner (last_winner),
      .winner      (pick_idx),
      .valid       (pick_vld)
   );

   assign pick_onehot = NUM_REQ'(1) << pick_idx;
   assign pick_data   = Req_Data[int'(pick_idx) * DATA_BITS +: DATA_BITS];

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] to_cnt;
   logic             aborted;

   // to_cnt holds the number of START cycles already completed, so the final
   // START cycle is the one where it reads TIMEOUT_CYCLES-1.
   assign to_hit = (state == START) && !Tx_Busy && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         to_cnt  <= '0;
         aborted <= 1'b0;
      end else begin
         if (state == START && state_nxt == START) begin
            to_cnt <= to_cnt + CNT_W'(1);
         end else begin
            to_cnt <= '0;
         end
         // remembers that the DONE being entered is an abort, so Timeout pulses with Ack
         if (to_hit) begin
            aborted <= 1'b1;
         end else if (state == DONE) begin
            aborted <= 1'b0;
         end
      end
   end

   assign Timeout = (state == DONE) && aborted;
`else
   assign to_hit  = 1'b0;
   assign Timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pick_vld && !Tx_Busy && !BIST_Busy) begin
               state_nxt = START;
            end
         end
         START: begin
            // a late Tx_Busy in the final START cycle still wins over the abort
            if (Tx_Busy) begin
               state_nxt = BUSY;
            end else if (to_hit) begin
               state_nxt = DONE;
            end
         end
         BUSY: begin
            if (!Tx_Busy) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= IDLE;
         grant       <= '0;
         tx_data     <= '0;
         win_idx     <= IDX_W'(NUM_REQ - 1);
         last_winner <= IDX_W'(NUM_REQ - 1);
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               // Req/Req_Data are only looked at here; the captured byte and owner
               // stay frozen until DONE regardless of what the requester does.
               if (state_nxt == START) begin
                  grant   <= pick_onehot;
                  tx_data <= pick_data;
                  win_idx <= pick_idx;
               end
            end
            DONE: begin
               grant       <= '0;
               last_winner <= win_idx;
            end
            default: begin
            end
         endcase
      end
   end

   assign Grant          = grant;
   assign Tx_Data        = tx_data;
   assign Transmit_Start = (state == START);
   assign Arb_Busy       = (state != IDLE);
   assign Ack            = (state == DONE) ? grant : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed steps, UART busy model and a grant/data scoreboard.
// Latency: n/a.
// Backpressure: the UART model raises Tx_Busy one cycle after Transmit_Start and holds it busy_len cycles.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DB = 8;
   localparam int TO = 64;

   typedef struct packed {
      logic [NR-1:0] grant;
      logic [DB-1:0] data;
   } exp_t;

   logic             Clk;
   logic             Rst_n;
   logic [NR-1:0]    Req;
   logic [NR*DB-1:0] Req_Data;
   logic [NR-1:0]    Grant;
   logic [NR-1:0]    Ack;
   logic [DB-1:0]    Tx_Data;
   logic             Transmit_Start;
   logic             Tx_Busy;
   logic             BIST_Busy;
   logic             Arb_Busy;
   logic             Timeout;

   int   tests = 0;
   int   fails = 0;
   exp_t sb_q[$];
   logic uart_en;
   int   busy_len = 12;
   logic in_xfer;

   uart_tx_arbiter #(
      .NUM_REQ        (NR),
      .DATA_BITS      (DB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .Clk            (Clk),
      .Rst_n          (Rst_n),
      .Req            (Req),
      .Req_Data       (Req_Data),
      .Grant          (Grant),
      .Ack            (Ack),
      .Tx_Data        (Tx_Data),
      .Transmit_Start (Transmit_Start),
      .Tx_Busy        (Tx_Busy),
      .BIST_Busy      (BIST_Busy),
      .Arb_Busy       (Arb_Busy),
      .Timeout        (Timeout)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d tests run", tests);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // all sampling and driving happens 1 time unit after the rising edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_data(input int idx, input logic [DB-1:0] d);
      Req_Data[idx*DB +: DB] = d;
   endtask

   task automatic push_exp(input int idx, input logic [DB-1:0] d);
      exp_t e;
      e.grant      = '0;
      e.grant[idx] = 1'b1;
      e.data       = d;
      sb_q.push_back(e);
   endtask

   task automatic wait_for_ack(input string tag, input int budget, output logic [NR-1:0] a);
      a = '0;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (Ack != '0) begin
            a = Ack;
            break;
         end
      end
      check(tag, 32'(a != '0), 32'd1);
   endtask

   // waits until the arbiter sits in BUSY (Arb_Busy, no start strobe, UART busy)
   task automatic wait_busy(input string tag, input int budget);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (Arb_Busy && !Transmit_Start && Tx_Busy) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   // UART transmitter model
   initial begin
      int  busy_cnt;
      logic pend;
      busy_cnt = 0;
      pend     = 1'b0;
      Tx_Busy  = 1'b0;
      forever begin
         @(negedge Clk);
         if (!Rst_n) begin
            Tx_Busy  = 1'b0;
            busy_cnt = 0;
            pend     = 1'b0;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) Tx_Busy = 1'b0;
         end else if (pend) begin
            pend     = 1'b0;
            Tx_Busy  = 1'b1;
            busy_cnt = busy_len;
         end else if (uart_en && Transmit_Start) begin
            pend = 1'b1;
         end
      end
   end

   // monitor: scoreboard on each new start strobe, invariants every cycle
   initial begin
      logic          prev_ts;
      logic          prev_ack;
      logic [NR-1:0] cur_grant;
      logic [DB-1:0] cur_data;
      exp_t          e;
      prev_ts   = 1'b0;
      prev_ack  = 1'b0;
      cur_grant = '0;
      cur_data  = '0;
      in_xfer   = 1'b0;
      forever begin
         tick();
         if (!Rst_n) begin
            prev_ts  = 1'b0;
            prev_ack = 1'b0;
            in_xfer  = 1'b0;
         end else begin
            check("grant_onehot0", 32'($onehot0(Grant)), 32'd1);
            check("ack_onehot0", 32'($onehot0(Ack)), 32'd1);
            if (Transmit_Start && !prev_ts) begin
               check("start_expected", 32'(sb_q.size() > 0), 32'd1);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  check("sb_grant", 32'(Grant), 32'(e.grant));
                  check("sb_data", 32'(Tx_Data), 32'(e.data));
                  cur_grant = e.grant;
                  cur_data  = e.data;
                  in_xfer   = 1'b1;
               end
            end else if (in_xfer) begin
               check("tx_data_stable", 32'(Tx_Data), 32'(cur_data));
               check("grant_stable", 32'(Grant), 32'(cur_grant));
            end
            if (Ack != '0) begin
               check("ack_in_xfer", 32'(in_xfer), 32'd1);
               check("ack_owner", 32'(Ack), 32'(cur_grant));
               check("ack_single_cycle", 32'(prev_ack), 32'd0);
               in_xfer = 1'b0;
            end
            prev_ts  = Transmit_Start;
            prev_ack = (Ack != '0);
         end
      end
   end

   initial begin
      logic [NR-1:0] a;
      logic          flag;
      int            n;
      int            order [5];
      order = '{0, 1, 2, 3, 0};

      Rst_n     = 1'b0;
      Req       = '0;
      Req_Data  = '0;
      BIST_Busy = 1'b0;
      uart_en   = 1'b1;
      repeat (3) tick();

      check("rst_grant", 32'(Grant), 32'd0);
      check("rst_ack", 32'(Ack), 32'd0);
      check("rst_tx_data", 32'(Tx_Data), 32'd0);
      check("rst_tx_start", 32'(Transmit_Start), 32'd0);
      check("rst_arb_busy", 32'(Arb_Busy), 32'd0);
      check("rst_timeout", 32'(Timeout), 32'd0);
      Rst_n = 1'b1;
      tick();

      // round robin with all four requesting from reset
      for (int i = 0; i < NR; i++) set_data(i, 8'h10 + 8'(i));
      for (int k = 0; k < 5; k++) push_exp(order[k], 8'h10 + 8'(order[k]));
      Req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_for_ack("rr_ack_seen", 40, a);
         check("rr_ack_order", 32'(a), 32'(1 << order[k]));
         if (k < 4) begin
            tick();
            check("gap_idle_start", 32'(Transmit_Start), 32'd0);
            check("gap_idle_busy", 32'(Arb_Busy), 32'd0);
            tick();
            check("gap_restart", 32'(Transmit_Start), 32'd1);
         end else begin
            Req = '0;
         end
      end

      // single requester: latency, data, ack timing
      tick();
      set_data(0, 8'hA5);
      push_exp(0, 8'hA5);
      Req = 4'b0001;
      tick();
      check("lat_tx_start", 32'(Transmit_Start), 32'd1);
      check("lat_grant", 32'(Grant), 32'h1);
      check("lat_tx_data", 32'(Tx_Data), 32'hA5);
      check("lat_arb_busy", 32'(Arb_Busy), 32'd1);
      flag = 1'b0;
      for (n = 0; n < 10 && !flag; n++) begin
         tick();
         flag = Tx_Busy;
      end
      check("uart_busy_seen", 32'(flag), 32'd1);
      tick();
      check("busy_start_low", 32'(Transmit_Start), 32'd0);
      flag = 1'b0;
      for (n = 0; n < 30 && !flag; n++) begin
         tick();
         flag = !Tx_Busy;
      end
      check("uart_idle_seen", 32'(flag), 32'd1);
      check("ack0_timing", 32'(Ack), 32'h1);
      Req = '0;
      tick();
      check("ack0_pulse_end", 32'(Ack), 32'd0);
      check("ack0_grant_clr", 32'(Grant), 32'd0);
      check("ack0_idle", 32'(Arb_Busy), 32'd0);

      // BIST holds off a grant; BIST rising mid-transfer does not disturb it
      BIST_Busy = 1'b1;
      set_data(1, 8'h21);
      push_exp(1, 8'h21);
      Req  = 4'b0010;
      flag = 1'b0;
      repeat (20) begin
         tick();
         flag = flag | (Grant != '0) | Arb_Busy;
      end
      check("bist_no_grant", 32'(flag), 32'd0);
      BIST_Busy = 1'b0;
      tick();
      check("bist_grant", 32'(Grant), 32'h2);
      check("bist_start", 32'(Transmit_Start), 32'd1);
      tick();
      BIST_Busy = 1'b1;
      wait_for_ack("bist_ack_seen", 40, a);
      check("bist_ack", 32'(a), 32'h2);
      Req = '0;
      tick();
      BIST_Busy = 1'b0;

      // reset cut in BUSY
      set_data(2, 8'h33);
      push_exp(2, 8'h33);
      Req = 4'b0100;
      wait_busy("rst_cut_busy", 40);
      check("rst_cut_grant", 32'(Grant), 32'h4);
      #2;
      Rst_n = 1'b0;
      #1;
      check("cut_grant", 32'(Grant), 32'd0);
      check("cut_ack", 32'(Ack), 32'd0);
      check("cut_tx_data", 32'(Tx_Data), 32'd0);
      check("cut_tx_start", 32'(Transmit_Start), 32'd0);
      check("cut_arb_busy", 32'(Arb_Busy), 32'd0);
      check("cut_timeout", 32'(Timeout), 32'd0);
      Req  = '0;
      flag = 1'b0;
      repeat (3) begin
         tick();
         flag = flag | (Ack != '0);
      end
      Rst_n = 1'b1;
      tick();
      flag = flag | (Ack != '0);
      check("cut_no_ack", 32'(flag), 32'd0);

      // pointer back at NUM_REQ-1 after reset: requester 2 beats 3
      set_data(2, 8'h44);
      set_data(3, 8'h55);
      push_exp(2, 8'h44);
      Req = 4'b1100;
      tick();
      check("post_rst_grant", 32'(Grant), 32'h4);
      wait_for_ack("post_rst_ack_seen", 40, a);
      check("post_rst_ack", 32'(a), 32'h4);
      Req = '0;
      tick();

      // requester drops Req mid-transfer; Ack still arrives
      set_data(1, 8'h66);
      push_exp(1, 8'h66);
      Req = 4'b0010;
      wait_busy("drop_busy", 40);
      Req = '0;
      wait_for_ack("drop_ack_seen", 40, a);
      check("drop_ack", 32'(a), 32'h2);
      tick();

      // transmitter never answers
      uart_en = 1'b0;
      set_data(0, 8'h77);
      push_exp(0, 8'h77);
      Req = 4'b0001;
      tick();
`ifdef UART_ARB_TIMEOUT_EN
      n = 0;
      while (Transmit_Start && n < 200) begin
         n++;
         tick();
      end
      check("to_start_cycles", 32'(n), 32'(TO));
      check("to_pulse", 32'(Timeout), 32'd1);
      check("to_ack", 32'(Ack), 32'h1);
      Req = '0;
      tick();
      check("to_pulse_end", 32'(Timeout), 32'd0);
      check("to_idle", 32'(Arb_Busy), 32'd0);
      uart_en = 1'b1;
`else
      flag = 1'b0;
      repeat (100) begin
         flag = flag | Timeout | !Transmit_Start;
         tick();
      end
      check("no_to_waits", 32'(flag), 32'd0);
      uart_en = 1'b1;
      wait_for_ack("no_to_ack_seen", 40, a);
      check("no_to_ack", 32'(a), 32'h1);
      check("no_to_timeout", 32'(Timeout), 32'd0);
      Req = '0;
      tick();
`endif

      tick();
      tick();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      check("no_open_xfer", 32'(in_xfer), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
